adis_frame_sequencer: RTL and testbench

- Controller that owns the single-word ADIS16209 SPI engine (req/done handshake, 16-bit command word, 16-bit response).
- After a boot delay it performs one configuration write. It then reads a fixed list of sensor registers on each periodic or external trigger.
- The ADIS16209 returns read data one frame late, so the block pipelines addresses (data for register k arrives on transaction k+1).
- Each sample is presented as a tagged strobe to downstream logging/packing logic.

---
 rtl/adis_pkg.sv | 27 ++
 rtl/adis_cmd_gap_timer.sv | 28 ++
 rtl/adis_frame_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_adis_frame_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adis_pkg.sv
// Shared definitions for the ADIS16209 frame sequencer: the register list,
// the command-word layout and the controller state encoding.
package adis_pkg;

    localparam int NUM_REGS = 8;

    // Registers read on every frame, in the order they are presented.
    localparam logic [6:0] REG_LIST [NUM_REGS] = '{
        7'h02, 7'h04, 7'h06, 7'h08, 7'h0A, 7'h0C, 7'h0E, 7'h10
    };

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_CFG  = 3'd1,
        ST_IDLE = 3'd2,
        ST_REQ  = 3'd3,
        ST_WAIT = 3'd4,
        ST_GAP  = 3'd5
    } state_t;

    // Command word sent to the SPI engine: data byte, a zero bit, address.
    function automatic logic [15:0] build_cmd(input logic [7:0] data,
                                              input logic [6:0] addr);
        return {data, 1'b0, addr};
    endfunction

endpackage

// File: rtl/adis_cmd_gap_timer.sv
// Shared down-counter. A load sets the count; it then decrements to zero
// and holds there. expired is high whenever the count is zero.
module adis_cmd_gap_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Load has priority over counting; the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/adis_frame_sequencer.sv
// ADIS16209 frame sequencer. Boots, writes one configuration register pair,
// then reads the register list once per trigger. Read data arrives one
// transaction late, so a frame is nine transactions and the last one is a
// dummy read whose only purpose is to collect the data of register 7.
//
// SPI handshake: spi_req is a one-cycle request; spi_wr_en and spi_data_tx are
// valid from the spi_req cycle and stay stable until the rising edge of
// spi_done, at which spi_data_rx is valid. Only that rising edge is acted on.
module adis_frame_sequencer
    import adis_pkg::*;
#(
    parameter int          BOOT_CYC    = 2000000,
    parameter int          STALL_CYC   = 160,
    parameter int          PERIOD_CYC  = 15360,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [6:0]  CFG_ADDR    = 7'h34,
    parameter logic [15:0] CFG_DATA    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    output logic        spi_req,
    output logic        spi_wr_en,
    output logic [15:0] spi_data_tx,
    input  logic [15:0] spi_data_rx,
    input  logic        spi_done,
    output logic        smp_valid,
    output logic [2:0]  smp_idx,
    output logic [15:0] smp_data,
    output logic        frame_done,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  overrun_cnt,
    output state_t      dbg_state
);

    localparam logic [31:0] BOOT_LD    = (BOOT_CYC > 0)    ? 32'(BOOT_CYC - 1)    : 32'd0;
    localparam logic [31:0] STALL_LD   = (STALL_CYC > 0)   ? 32'(STALL_CYC - 1)   : 32'd0;
    localparam logic [31:0] TIMEOUT_LD = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;
    localparam logic [31:0] PER_LAST   = (PERIOD_CYC > 0)  ? 32'(PERIOD_CYC - 1)  : 32'd0;
    localparam bit          PER_EN     = (PERIOD_CYC > 0);
    localparam logic [3:0]  LAST_K     = 4'd8;

    state_t      state, state_n;
    logic [3:0]  k, k_n;
    logic        cfg_mode, cfg_mode_n;
    logic        cfg_idx, cfg_idx_n;
    logic        aborted, aborted_n;
    logic        boot_loaded, boot_loaded_n;
    logic        spi_done_q;
    logic        tmr_load, tmr_expired, set_timeout;
    logic [31:0] tmr_val;
    logic [31:0] period_cnt;
    logic        period_run;
    logic        tick, trig_any, done_edge, sample_now;
    logic [3:0]  k_m1;
    logic [2:0]  reg_idx;
    logic [15:0] cmd_n;

    assign done_edge  = spi_done & ~spi_done_q;
    assign tick       = PER_EN && period_run && (period_cnt == PER_LAST);
    assign trig_any   = trig | tick;
    assign sample_now = (state == ST_WAIT) && done_edge && !cfg_mode && (k != 4'd0);
    assign k_m1       = k - 4'd1;
    assign spi_req    = (state == ST_REQ);
    assign dbg_state  = state;

    adis_cmd_gap_timer #(.W(32)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    // Next-state logic; also decides when the shared timer is reloaded.
    always_comb begin
        state_n       = state;
        k_n           = k;
        cfg_mode_n    = cfg_mode;
        cfg_idx_n     = cfg_idx;
        aborted_n     = aborted;
        boot_loaded_n = boot_loaded;
        tmr_load      = 1'b0;
        tmr_val       = 32'd0;
        set_timeout   = 1'b0;
        case (state)
            ST_BOOT: begin
                if (!boot_loaded) begin
                    tmr_load      = 1'b1;
                    tmr_val       = BOOT_LD;
                    boot_loaded_n = 1'b1;
                end else if (tmr_expired) begin
                    state_n = ST_CFG;
                end
            end
            ST_CFG: begin
                cfg_mode_n = 1'b1;
                cfg_idx_n  = 1'b0;
                aborted_n  = 1'b0;
                state_n    = ST_REQ;
            end
            ST_IDLE: begin
                if (trig_any) begin
                    k_n       = 4'd0;
                    aborted_n = 1'b0;
                    state_n   = ST_REQ;
                end
            end
            ST_REQ: begin
                tmr_load = 1'b1;
                tmr_val  = TIMEOUT_LD;
                state_n  = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_edge) begin
                    tmr_load = 1'b1;
                    tmr_val  = STALL_LD;
                    state_n  = ST_GAP;
                end else if (tmr_expired) begin
                    set_timeout = 1'b1;
                    aborted_n   = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = STALL_LD;
                    state_n     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tmr_expired) begin
                    if (aborted) begin
                        cfg_mode_n = 1'b0;
                        state_n    = ST_IDLE;
                    end else if (cfg_mode) begin
                        if (!cfg_idx) begin
                            cfg_idx_n = 1'b1;
                            state_n   = ST_REQ;
                        end else begin
                            cfg_mode_n = 1'b0;
                            state_n    = ST_IDLE;
                        end
                    end else if (k < LAST_K) begin
                        k_n     = k + 4'd1;
                        state_n = ST_REQ;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_BOOT;
        endcase
    end

    // Command word for the transaction about to be requested.
    always_comb begin
        reg_idx = (k_n == LAST_K) ? 3'd0 : k_n[2:0];
        if (cfg_mode_n) begin
            cmd_n = cfg_idx_n ? build_cmd(CFG_DATA[15:8], CFG_ADDR + 7'd1)
                              : build_cmd(CFG_DATA[7:0], CFG_ADDR);
        end else begin
            cmd_n = build_cmd(8'h00, REG_LIST[reg_idx]);
        end
    end

    // State register, command latch, sample strobe and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BOOT;
            k           <= 4'd0;
            cfg_mode    <= 1'b0;
            cfg_idx     <= 1'b0;
            aborted     <= 1'b0;
            boot_loaded <= 1'b0;
            spi_done_q  <= 1'b0;
            spi_wr_en   <= 1'b0;
            spi_data_tx <= 16'h0000;
            smp_valid   <= 1'b0;
            smp_idx     <= 3'd0;
            smp_data    <= 16'h0000;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            cfg_mode    <= cfg_mode_n;
            cfg_idx     <= cfg_idx_n;
            aborted     <= aborted_n;
            boot_loaded <= boot_loaded_n;
            spi_done_q  <= spi_done;
            busy        <= (state_n != ST_IDLE);
            if (state_n == ST_REQ) begin
                spi_wr_en   <= cfg_mode_n;
                spi_data_tx <= cmd_n;
            end
            smp_valid  <= sample_now;
            frame_done <= sample_now && (k == LAST_K);
            if (sample_now) begin
                smp_idx  <= k_m1[2:0];
                smp_data <= spi_data_rx;
            end
            if (set_timeout) begin
                timeout_err <= 1'b1;
            end
            if (trig_any && (state != ST_IDLE) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

    // Internal trigger period counter, free-running once boot has finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_run <= 1'b0;
            period_cnt <= 32'd0;
        end else begin
            if ((state == ST_BOOT) && (state_n == ST_CFG)) begin
                period_run <= 1'b1;
            end
            if (PER_EN && period_run) begin
                period_cnt <= tick ? 32'd0 : period_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_adis_frame_sequencer.sv
// Bench for adis_frame_sequencer: a behavioural SPI responder, a monitor with
// expected queues for requests and samples, a table of frame scenarios plus
// random frames, and directed boot, timeout, reset and periodic-trigger cases.
module tb_adis_frame_sequencer;
  import adis_pkg::*;

  localparam int          BOOT_CYC    = 10;
  localparam int          STALL_CYC   = 8;
  localparam int          TIMEOUT_CYC = 600;
  localparam int          PERIOD2     = 4000;
  localparam logic [6:0]  CFG_ADDR    = 7'h34;
  localparam logic [15:0] CFG_DATA    = 16'h1234;
  localparam int          LAT_DEFAULT = 263;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, trig, spi_done;
  logic [15:0] spi_data_rx;
  logic        spi_req, spi_wr_en, smp_valid, frame_done, busy, timeout_err;
  logic [15:0] spi_data_tx, smp_data;
  logic [2:0]  smp_idx;
  logic [7:0]  overrun_cnt;
  state_t      dbg_state;

  adis_frame_sequencer #(
    .BOOT_CYC(BOOT_CYC), .STALL_CYC(STALL_CYC), .PERIOD_CYC(0),
    .TIMEOUT_CYC(TIMEOUT_CYC), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .spi_req(spi_req), .spi_wr_en(spi_wr_en),
    .spi_data_tx(spi_data_tx), .spi_data_rx(spi_data_rx), .spi_done(spi_done),
    .smp_valid(smp_valid), .smp_idx(smp_idx), .smp_data(smp_data),
    .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err),
    .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
  );

  // second instance exercising the internal period trigger
  logic        rst2, trig2, spi_done2, spi_req2, spi_wr_en2, smp_valid2, frame_done2, busy2, timeout_err2;
  logic [15:0] spi_data_rx2, spi_data_tx2, smp_data2;
  logic [2:0]  smp_idx2;
  logic [7:0]  overrun_cnt2;
  state_t      dbg_state2;

  adis_frame_sequencer #(
    .BOOT_CYC(BOOT_CYC), .STALL_CYC(STALL_CYC), .PERIOD_CYC(PERIOD2),
    .TIMEOUT_CYC(TIMEOUT_CYC), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA)
  ) dut2 (
    .clk(clk), .rst(rst2), .trig(trig2), .spi_req(spi_req2), .spi_wr_en(spi_wr_en2),
    .spi_data_tx(spi_data_tx2), .spi_data_rx(spi_data_rx2), .spi_done(spi_done2),
    .smp_valid(smp_valid2), .smp_idx(smp_idx2), .smp_data(smp_data2),
    .frame_done(frame_done2), .busy(busy2), .timeout_err(timeout_err2),
    .overrun_cnt(overrun_cnt2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [16:0] exp_tx_q[$];   // {wr_en, command word}
  logic [18:0] exp_q[$];      // {idx, data}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Register list as the datasheet describes it: even addresses 0x02..0x10.
  function automatic logic [6:0] reg_addr(input int i);
    return 7'(2 * ((i % 8) + 1));
  endfunction

  // ---------------- SPI responder model (main DUT) ----------------
  logic       withhold = 1'b0;
  int         cur_lat = LAT_DEFAULT;
  int         cur_hold = 1;
  logic [6:0] prev_addr = 7'h00;
  logic [6:0] mdl_addr;
  bit         mdl_killed;

  initial begin
    spi_done = 1'b0;
    spi_data_rx = 16'h0000;
    forever begin
      @(negedge clk);
      if (spi_req && !rst) begin
        mdl_addr = spi_data_tx[6:0];
        if (!withhold) begin
          mdl_killed = 1'b0;
          for (int i = 0; i < cur_lat; i++) begin
            @(posedge clk);
            if (rst) begin
              mdl_killed = 1'b1;
              break;
            end
          end
          if (!mdl_killed) begin
            #1;
            spi_data_rx = 16'hA000 | (16'(prev_addr) << 4);
            spi_done = 1'b1;
            for (int i = 0; i < cur_hold; i++) @(posedge clk);
            #1 spi_done = 1'b0;
          end
        end
        prev_addr = mdl_addr;
      end
    end
  end

  // simple fixed-latency responder for the periodic instance
  initial begin
    spi_done2 = 1'b0;
    spi_data_rx2 = 16'h0000;
    forever begin
      @(negedge clk);
      if (spi_req2) begin
        repeat (12) @(posedge clk);
        #1 spi_done2 = 1'b1;
        spi_data_rx2 = 16'hA000;
        @(posedge clk);
        #1 spi_done2 = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          n_req = 0;
  int          n_smp = 0;
  int          n_fd = 0;
  int          last_done_cyc = -1;
  logic        done_q = 1'b0;
  logic [16:0] last_req_val = '0;
  logic [16:0] mon_e;
  logic [18:0] mon_s;

  always @(negedge clk) begin
    cyc++;
    if (spi_done && !done_q) begin
      last_done_cyc = cyc;
      check("tx_held_to_done", {spi_wr_en, spi_data_tx}, last_req_val);
    end
    done_q = spi_done;
    if (rst) last_done_cyc = -1;
    if (spi_req) begin
      n_req++;
      last_req_val = {spi_wr_en, spi_data_tx};
      if (last_done_cyc >= 0)
        check("gap_idle_cycles_ge_stall", 32'((cyc - last_done_cyc - 1) >= STALL_CYC), 1);
      if (exp_tx_q.size() == 0) begin
        check("unexpected_req", {spi_wr_en, spi_data_tx}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_tx_q.pop_front();
        check("req_wr_en_tx", {spi_wr_en, spi_data_tx}, mon_e);
      end
    end
    if (smp_valid) begin
      n_smp++;
      if (exp_q.size() == 0) begin
        check("unexpected_sample", {smp_idx, smp_data}, 32'hFFFF_FFFF);
      end else begin
        mon_s = exp_q.pop_front();
        check("sample_idx_data", {smp_idx, smp_data}, mon_s);
      end
    end
    if (frame_done) begin
      n_fd++;
      check("frame_done_with_idx7", {smp_valid, smp_idx}, {1'b1, 3'd7});
    end
  end

  int cyc2 = 0;
  int fd2_last = -1;
  int n_int2 = 0;
  always @(negedge clk) begin
    cyc2++;
    if (frame_done2) begin
      if (fd2_last >= 0 && n_int2 < 3) begin
        check("period_frame_interval", cyc2 - fd2_last, PERIOD2);
        n_int2++;
      end
      fd2_last = cyc2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_busy_low(input string name, input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, {31'b0, busy}, 0);
  endtask

  task automatic push_frame_expect();
    for (int i = 0; i < 9; i++) exp_tx_q.push_back({1'b0, 8'h00, 1'b0, reg_addr(i)});
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 16'hA000 | (16'(reg_addr(i)) << 4)});
  endtask

  task automatic push_cfg_expect();
    exp_tx_q.push_back({1'b1, CFG_DATA[7:0], 1'b0, CFG_ADDR});
    exp_tx_q.push_back({1'b1, CFG_DATA[15:8], 1'b0, 7'(CFG_ADDR + 7'd1)});
  endtask

  task automatic run_frame(input string name, input int lat, input int hold, input int mid,
                           input int exp_samples, input int exp_fd);
    int r0, s0, f0, ov0, left, t;
    cur_lat = lat;
    cur_hold = hold;
    push_frame_expect();
    r0 = n_req; s0 = n_smp; f0 = n_fd; ov0 = int'(overrun_cnt);
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    left = mid;
    t = 0;
    while (!(n_fd > f0 && busy === 1'b0) && t < 20000) begin
      if (left > 0 && (n_req - r0) >= 2 * (mid - left + 1)) begin
        trig = 1'b1;
        left--;
      end
      @(negedge clk);
      trig = 1'b0;
      t++;
    end
    check($sformatf("%s_completes", name), 32'(t < 20000), 1);
    check($sformatf("%s_reads", name), n_req - r0, 9);
    check($sformatf("%s_samples", name), n_smp - s0, exp_samples);
    check($sformatf("%s_frame_done", name), n_fd - f0, exp_fd);
    check($sformatf("%s_overrun", name), {24'b0, overrun_cnt}, ov0 + mid);
    check($sformatf("%s_exp_q_empty", name), exp_q.size() + exp_tx_q.size(), 0);
    exp_q.delete();
    exp_tx_q.delete();
  endtask

  // ---------------- table of frame scenarios ----------------
  typedef struct {
    int lat;
    int hold;
    int mid;
    int exp_samples;
    int exp_fd;
  } vec_t;

  vec_t vecs[4];

  // ---------------- main sequence ----------------
  initial begin
    int t, r0, s0, f0;
    vecs[0] = '{263, 1, 0, 8, 1};
    vecs[1] = '{263, 3, 2, 8, 1};
    vecs[2] = '{30, 2, 1, 8, 1};
    vecs[3] = '{4, 1, 3, 8, 1};

    rst = 1'b1; trig = 1'b0; rst2 = 1'b1; trig2 = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_spi_req", {31'b0, spi_req}, 0);
    check("rst_wr_en_tx", {spi_wr_en, spi_data_tx}, 0);
    check("rst_smp", {smp_valid, smp_idx, smp_data, frame_done}, 0);
    check("rst_busy_timeout", {busy, timeout_err}, 0);
    check("rst_overrun", {24'b0, overrun_cnt}, 0);

    // boot and configuration writes
    push_cfg_expect();
    @(posedge clk); #1 rst = 1'b0; rst2 = 1'b0;
    t = 0;
    while (!spi_req && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("boot_delay_min", 32'(t >= BOOT_CYC), 1);
    check("boot_delay_max", 32'(t <= BOOT_CYC + 6), 1);
    wait_busy_low("cfg_busy_falls", 3000);
    check("cfg_two_writes", n_req, 2);
    check("cfg_exp_tx_empty", exp_tx_q.size(), 0);
    exp_tx_q.delete();

    // table-driven frames
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].lat, vecs[i].hold, vecs[i].mid,
                vecs[i].exp_samples, vecs[i].exp_fd);

    // random frames
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("rnd%0d", i), int'($urandom_range(4, 300)),
                int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), 8, 1);

    // timeout: responder withholds spi_done
    withhold = 1'b1;
    exp_tx_q.push_back({1'b0, 8'h00, 1'b0, reg_addr(0)});
    r0 = n_req; s0 = n_smp; f0 = n_fd;
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    t = 0;
    while (!spi_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (timeout_err !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("timeout_err_set", {31'b0, timeout_err}, 1);
    check("timeout_latency_min", 32'(t >= TIMEOUT_CYC), 1);
    check("timeout_latency_max", 32'(t <= TIMEOUT_CYC + 3), 1);
    wait_busy_low("timeout_busy_falls", 200);
    check("timeout_state_idle", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    check("timeout_one_read", n_req - r0, 1);
    check("timeout_no_samples", n_smp - s0, 0);
    check("timeout_no_frame_done", n_fd - f0, 0);
    exp_tx_q.delete();
    withhold = 1'b0;
    run_frame("after_timeout", LAT_DEFAULT, 1, 0, 8, 1);
    check("timeout_err_sticky", {31'b0, timeout_err}, 1);

    // reset during the k=4 transaction
    cur_lat = LAT_DEFAULT;
    cur_hold = 1;
    push_frame_expect();
    r0 = n_req;
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    t = 0;
    while ((n_req - r0) < 5 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("reset_reached_k4", n_req - r0, 5);
    repeat (50) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_spi_req", {31'b0, spi_req}, 0);
    check("midrst_wr_en_tx", {spi_wr_en, spi_data_tx}, 0);
    check("midrst_smp", {smp_valid, smp_idx, smp_data, frame_done}, 0);
    check("midrst_status", {busy, timeout_err, overrun_cnt}, 0);
    exp_q.delete();
    exp_tx_q.delete();
    s0 = n_smp;
    r0 = n_req;
    push_cfg_expect();
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    wait_busy_low("reboot_busy_falls", 3000);
    check("reboot_two_writes", n_req - r0, 2);
    check("reboot_no_samples", n_smp - s0, 0);
    check("reboot_exp_tx_empty", exp_tx_q.size(), 0);
    exp_tx_q.delete();
    run_frame("after_reset", 40, 2, 0, 8, 1);

    // periodic instance: wait for three frame intervals
    t = 0;
    while (n_int2 < 3 && t < 30000) begin
      @(negedge clk);
      t++;
    end
    check("period_intervals_seen", n_int2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall guard so the run always ends
  initial begin
    #900000;
    $display("FAIL global_watchdog: got time limit expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
